// File: rtl/stack_ptr_bank_if.sv
// Command and RAM-request bundle between the control unit and the stack-pointer bank.
// The master drives commands and read acks; the slave answers with ready and RAM strobes.
interface stack_ptr_bank_if #(
    parameter int SEL_W  = 2,
    parameter int ADDR_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [SEL_W-1:0]  cmd_sel;
    logic              rd_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;

    modport master (
        output cmd_valid, cmd_op, cmd_sel, rd_ack,
        input  cmd_ready, mem_req, mem_we, mem_addr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, rd_ack,
        output cmd_ready, mem_req, mem_we, mem_addr
    );
endinterface

// File: rtl/stack_ptr_bank.sv
// NSTACK hardware stack pointers in RAM pages; RAM request one cycle after accept.
// Pushes stream every cycle; pop/peek hold cmd_ready low until rd_ack.
module stack_ptr_bank #(
    parameter int               NSTACK    = 4,
    parameter int               SEL_W     = 2,
    parameter int               PTR_W     = 8,
    parameter int               PAGE_W    = 8,
    parameter logic [PAGE_W-1:0] BASE_PAGE = 8'h2B
) (
    input  logic                clk,
    input  logic                rst,
    stack_ptr_bank_if.slave     bus,
    input  logic                flush,
    input  logic                err_clr,
    output logic [NSTACK-1:0]   stk_empty,
    output logic [NSTACK-1:0]   stk_full,
    output logic                err_ovf,
    output logic                err_unf
);
    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam logic [1:0]       OP_PUSH = 2'b00;
    localparam logic [1:0]       OP_POP  = 2'b01;
    localparam logic [1:0]       OP_PEEK = 2'b10;
    localparam logic [1:0]       OP_CLR  = 2'b11;
    localparam logic [PTR_W-1:0] PTR_MAX = '1;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr [NSTACK];
    logic [SEL_W-1:0] lat_sel;
    logic             lat_pop;

    logic [PTR_W-1:0]  sel_ptr;
    logic [PAGE_W-1:0] sel_page;
    logic              push_ok, rd_ok, clr_ok, ack_pop, ovf_set, unf_set;

    assign sel_ptr       = ptr[bus.cmd_sel];
    assign sel_page      = BASE_PAGE - PAGE_W'(bus.cmd_sel);
    assign bus.cmd_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        push_ok   = 1'b0;
        rd_ok     = 1'b0;
        clr_ok    = 1'b0;
        ack_pop   = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        case (bus.cmd_op)
                            OP_PUSH: begin
                                if (sel_ptr == PTR_MAX) ovf_set = 1'b1;
                                else                    push_ok = 1'b1;
                            end
                            OP_POP, OP_PEEK: begin
                                if (sel_ptr == '0) begin
                                    unf_set = 1'b1;
                                end else begin
                                    rd_ok     = 1'b1;
                                    state_nxt = RD_WAIT;
                                end
                            end
                            OP_CLR:  clr_ok = 1'b1;
                            default: ;
                        endcase
                    end
                end
                RD_WAIT: begin
                    if (bus.rd_ack) begin
                        ack_pop   = lat_pop;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Only one of push/clear/ack can target a stack in any cycle, so the chain never conflicts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSTACK; k++) ptr[k] <= '0;
        end else begin
            for (int k = 0; k < NSTACK; k++) begin
                if (flush)
                    ptr[k] <= '0;
                else if (push_ok && bus.cmd_sel == SEL_W'(k))
                    ptr[k] <= ptr[k] + PTR_W'(1);
                else if (clr_ok && bus.cmd_sel == SEL_W'(k))
                    ptr[k] <= '0;
                else if (ack_pop && lat_sel == SEL_W'(k))
                    ptr[k] <= ptr[k] - PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_req  <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            lat_sel      <= '0;
            lat_pop      <= 1'b0;
        end else begin
            bus.mem_req <= push_ok | rd_ok;
            bus.mem_we  <= push_ok;
            if (push_ok) bus.mem_addr <= {sel_page, sel_ptr + PTR_W'(1)};
            else if (rd_ok) bus.mem_addr <= {sel_page, sel_ptr};
            if (rd_ok) begin
                lat_sel <= bus.cmd_sel;
                lat_pop <= (bus.cmd_op == OP_POP);
            end
        end
    end

    // Clearing wins over a same-cycle error; flush leaves the flags alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else if (err_clr) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            err_ovf <= err_ovf | ovf_set;
            err_unf <= err_unf | unf_set;
        end
    end

    always_comb begin
        for (int k = 0; k < NSTACK; k++) begin
            stk_empty[k] = (ptr[k] == '0);
            stk_full[k]  = (ptr[k] == PTR_MAX);
        end
    end
endmodule
